// File: rtl/bicubic_refpx_block_ctrl_pkg.sv
// Shared types and constants for the 4x4 reference-pixel block sequencer.
// State encoding and block-buffer padding mux select codes.
package bicubic_refpx_block_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH1 = 3'd3,
        ST_FLUSH2 = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam logic [3:0] MUX_NORMAL = 4'b0000;
    localparam logic [3:0] MUX_PAD_L  = 4'b0001;
    localparam logic [3:0] MUX_PAD_R1 = 4'b0100;
    localparam logic [3:0] MUX_PAD_R2 = 4'b1000;

endpackage

// File: rtl/bicubic_refpx_block_ctrl_if.sv
// Column-in / block-out handshake bundle between line buffer, block buffer and Bicubic core.
// master = sequencer side, slave = surrounding datapath / environment.
interface bicubic_refpx_block_ctrl_if #(
    parameter int X_W = 12,
    parameter int Y_W = 12
);
    logic           s_valid;
    logic           s_ready;
    logic           buf_wren;
    logic [3:0]     buf_mux_ctrl;
    logic           blk_valid;
    logic           blk_ready;
    logic [X_W-1:0] blk_x;
    logic [Y_W-1:0] blk_y;
    logic           blk_eol;
    logic           blk_eof;

    modport master (
        input  s_valid, blk_ready,
        output s_ready, buf_wren, buf_mux_ctrl, blk_valid, blk_x, blk_y, blk_eol, blk_eof
    );

    modport slave (
        output s_valid, blk_ready,
        input  s_ready, buf_wren, buf_mux_ctrl, blk_valid, blk_x, blk_y, blk_eol, blk_eof
    );
endinterface

// File: rtl/bicubic_refpx_block_ctrl.sv
// Sequencer for the 4x4 reference-pixel block buffer: accepts 4-row columns, adds two
// right-edge flush shifts per line and presents one block per output centre column.
module bicubic_refpx_block_ctrl
    import bicubic_refpx_block_ctrl_pkg::*;
#(
    parameter int X_W = 12,
    parameter int Y_W = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clken,
    input  logic                 i_start,
    input  logic [X_W-1:0]       i_cfg_width,
    input  logic [Y_W-1:0]       i_cfg_height,
    output logic                 o_cfg_err,
    output logic                 o_busy,
    bicubic_refpx_block_ctrl_if.master bus
);

    state_t         r_state, w_state_n;
    logic [X_W-1:0] r_width, r_col, w_col_n;
    logic [Y_W-1:0] r_height, r_y, w_y_n;
    logic           r_busy, w_busy_n, r_cfg_err, w_cfg_err_n, w_load;
    logic           r_blk_valid, r_blk_eol, r_blk_eof;
    logic [X_W-1:0] r_blk_x, w_emit_x;
    logic [Y_W-1:0] r_blk_y;
    logic [3:0]     r_mux, w_emit_mux;
    logic           w_free, w_s_ready, w_take, w_flush, w_last_col, w_last_line;
    logic           w_emit, w_emit_eol, w_emit_eof;

    // Handshake qualification and next-state / block-emission decode
    always_comb begin
        w_free      = !r_blk_valid || bus.blk_ready;
        w_s_ready   = ((r_state == ST_FILL) || (r_state == ST_STREAM)) && w_free;
        w_take      = i_clken && bus.s_valid && w_s_ready;
        w_flush     = i_clken && w_free && ((r_state == ST_FLUSH1) || (r_state == ST_FLUSH2));
        w_last_col  = (r_col == (r_width - X_W'(1)));
        w_last_line = (r_y == (r_height - Y_W'(1)));

        w_state_n   = r_state;
        w_col_n     = r_col;
        w_y_n       = r_y;
        w_busy_n    = r_busy;
        w_cfg_err_n = 1'b0;
        w_load      = 1'b0;
        w_emit      = 1'b0;
        w_emit_x    = '0;
        w_emit_mux  = MUX_NORMAL;
        w_emit_eol  = 1'b0;
        w_emit_eof  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && (i_cfg_width >= X_W'(4)) && (i_cfg_height != Y_W'(0))) begin
                    w_load    = 1'b1;
                    w_busy_n  = 1'b1;
                    w_col_n   = '0;
                    w_y_n     = '0;
                    w_state_n = ST_FILL;
                end else begin
                    w_cfg_err_n = i_start;
                end
            end
            ST_FILL: begin
                if (w_take) begin
                    w_col_n   = r_col + X_W'(1);
                    w_state_n = (r_col == X_W'(1)) ? ST_STREAM : ST_FILL;
                end else begin
                    w_col_n = r_col;
                end
            end
            // Column k completes the block centred on k-2; column 2 is the left-padded one
            ST_STREAM: begin
                if (w_take) begin
                    w_col_n    = r_col + X_W'(1);
                    w_emit     = 1'b1;
                    w_emit_x   = r_col - X_W'(2);
                    w_emit_mux = (r_col == X_W'(2)) ? MUX_PAD_L : MUX_NORMAL;
                    w_state_n  = w_last_col ? ST_FLUSH1 : ST_STREAM;
                end else begin
                    w_col_n = r_col;
                end
            end
            ST_FLUSH1: begin
                if (w_flush) begin
                    w_emit     = 1'b1;
                    w_emit_x   = r_width - X_W'(2);
                    w_emit_mux = MUX_PAD_R1;
                    w_state_n  = ST_FLUSH2;
                end else begin
                    w_state_n = ST_FLUSH1;
                end
            end
            ST_FLUSH2: begin
                if (w_flush) begin
                    w_emit     = 1'b1;
                    w_emit_x   = r_width - X_W'(1);
                    w_emit_mux = MUX_PAD_R2;
                    w_emit_eol = 1'b1;
                    w_emit_eof = w_last_line;
                    if (w_last_line) begin
                        w_state_n = ST_DRAIN;
                    end else begin
                        w_y_n     = r_y + Y_W'(1);
                        w_col_n   = '0;
                        w_state_n = ST_FILL;
                    end
                end else begin
                    w_state_n = ST_FLUSH2;
                end
            end
            ST_DRAIN: begin
                if (r_blk_valid && bus.blk_ready) begin
                    w_busy_n  = 1'b0;
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_DRAIN;
                end
            end
            default: begin
                w_busy_n  = 1'b0;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and the presented-block registers; everything frozen while clken is low
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_col       <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_x     <= '0;
            r_blk_y     <= '0;
            r_mux       <= MUX_NORMAL;
            r_blk_eol   <= 1'b0;
            r_blk_eof   <= 1'b0;
        end else if (i_clken) begin
            r_state   <= w_state_n;
            r_col     <= w_col_n;
            r_y       <= w_y_n;
            r_busy    <= w_busy_n;
            r_cfg_err <= w_cfg_err_n;
            if (w_load) begin
                r_width  <= i_cfg_width;
                r_height <= i_cfg_height;
            end
            // A new block overwrites the one consumed on this same edge
            if (w_emit) begin
                r_blk_valid <= 1'b1;
                r_blk_x     <= w_emit_x;
                r_blk_y     <= r_y;
                r_mux       <= w_emit_mux;
                r_blk_eol   <= w_emit_eol;
                r_blk_eof   <= w_emit_eof;
            end else if (bus.blk_ready) begin
                r_blk_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.buf_wren     = w_take || w_flush;
    assign bus.buf_mux_ctrl = r_mux;
    assign bus.blk_valid    = r_blk_valid;
    assign bus.blk_x        = r_blk_x;
    assign bus.blk_y        = r_blk_y;
    assign bus.blk_eol      = r_blk_eol;
    assign bus.blk_eof      = r_blk_eof;
    assign o_cfg_err        = r_cfg_err;
    assign o_busy           = r_busy;

endmodule
